// File: rtl/lfsr_seeder.sv
// Seedable Fibonacci LFSR with a byte-serial, MSB-first snapshot dump port.
// A synchronous clear, a seed load and a dump request share the cycle
// with stepping. Priority is rst > lfsr_load > dump > en.
module lfsr_seeder #(
   parameter int unsigned        WIDTH        = 64,
   parameter logic [WIDTH-1:0]   TAPS         = 64'hD800_0000_0000_0000,
   parameter logic [WIDTH-1:0]   DEFAULT_SEED = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rst,
   input  logic             en,
   input  logic             lfsr_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             dump,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic [WIDTH-1:0] lfsr_q,
   output logic             busy,
   output logic             zero_fix
);

   // WIDTH is expected to be a multiple of 8 and at least 16.
   localparam int unsigned NBYTES = WIDTH / 8;
   localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      DUMP = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         rst_sync;
   logic               rst_n_int;
   logic [WIDTH-1:0]   step_val;
   logic [WIDTH-1:0]   lfsr_nxt;
   logic [WIDTH-1:0]   snap, snap_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic               valid_nxt;
   logic [7:0]         data_nxt;
   logic               last_nxt;
   logic               zf_nxt;

   // Byte i of v, counted from the most significant byte.
   function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] v,
                                           input logic [IDX_W-1:0] i);
      logic [WIDTH-1:0] sh;
      sh = v << {i, 3'b000};
      return sh[WIDTH-1 -: 8];
   endfunction

   // Reset synchroniser: asserts immediately, releases on the second edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n_int = rst_sync[1];

   // One Fibonacci step; a degenerate all-zero result falls back to the seed.
   always_comb begin
      step_val = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      if (step_val == '0) step_val = DEFAULT_SEED;
   end

   // Next-state and datapath decode in priority order.
   always_comb begin
      state_nxt = state;
      lfsr_nxt  = lfsr_q;
      snap_nxt  = snap;
      idx_nxt   = idx;
      valid_nxt = out_valid;
      data_nxt  = out_data;
      last_nxt  = out_last;
      zf_nxt    = zero_fix;

      if (rst) begin
         lfsr_nxt  = DEFAULT_SEED;
         zf_nxt    = 1'b0;
         valid_nxt = 1'b0;
         last_nxt  = 1'b0;
         data_nxt  = 8'h00;
         idx_nxt   = '0;
         state_nxt = IDLE;
      end else if (lfsr_load) begin
         if (seed == '0) begin
            lfsr_nxt = DEFAULT_SEED;
            zf_nxt   = 1'b1;
         end else begin
            lfsr_nxt = seed;
         end
         valid_nxt = 1'b0;
         last_nxt  = 1'b0;
         idx_nxt   = '0;
         state_nxt = IDLE;
      end else begin
         if (en) lfsr_nxt = step_val;
         case (state)
            IDLE: begin
               if (dump) begin
                  snap_nxt  = lfsr_q;
                  idx_nxt   = '0;
                  data_nxt  = byte_sel(lfsr_q, IDX_W'(0));
                  last_nxt  = (LAST_IDX == IDX_W'(0));
                  valid_nxt = 1'b1;
                  state_nxt = DUMP;
               end
            end
            DUMP: begin
               if (out_valid && out_ready) begin
                  if (idx == LAST_IDX) begin
                     valid_nxt = 1'b0;
                     last_nxt  = 1'b0;
                     state_nxt = IDLE;
                  end else begin
                     idx_nxt  = idx + IDX_W'(1);
                     data_nxt = byte_sel(snap, idx_nxt);
                     last_nxt = (idx_nxt == LAST_IDX);
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state     <= IDLE;
         lfsr_q    <= DEFAULT_SEED;
         snap      <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         zero_fix  <= 1'b0;
      end else begin
         state     <= state_nxt;
         lfsr_q    <= lfsr_nxt;
         snap      <= snap_nxt;
         idx       <= idx_nxt;
         out_valid <= valid_nxt;
         out_data  <= data_nxt;
         out_last  <= last_nxt;
         busy      <= (state_nxt == DUMP);
         zero_fix  <= zf_nxt;
      end
   end

endmodule

// File: tb/tb_lfsr_seeder.sv
// Bench for lfsr_seeder: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lfsr_seeder;

   localparam int unsigned NB    = 8;
   localparam logic [63:0] TAPS  = 64'hD800_0000_0000_0000;
   localparam logic [63:0] DSEED = 64'h1;
   localparam logic [63:0] SEQ   = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        lfsr_load = 1'b0;
   logic [63:0] seed = '0;
   logic        dump = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [63:0] lfsr_q;
   logic        busy;
   logic        zero_fix;

   lfsr_seeder dut (
      .clk       (clk),
      .reset     (reset),
      .rst       (rst),
      .en        (en),
      .lfsr_load (lfsr_load),
      .seed      (seed),
      .dump      (dump),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .lfsr_q    (lfsr_q),
      .busy      (busy),
      .zero_fix  (zero_fix)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_on   = 1'b0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   // Reference model: register value, sticky flag, and the bytes still owed.
   logic [63:0] m_lfsr = DSEED;
   bit          m_zf   = 1'b0;
   logic [7:0]  m_q[$];
   int          m_hold = 0;

   function automatic logic [63:0] lfsr_next(input logic [63:0] v);
      logic [63:0] n;
      n = {v[62:0], ^(v & TAPS)};
      if (n == 64'h0) n = DSEED;
      return n;
   endfunction

   function void m_reset();
      m_lfsr = DSEED;
      m_zf   = 1'b0;
      m_q.delete();
   endfunction

   always @(negedge reset) begin
      m_reset();
      m_hold = 2;
   end

   always @(posedge clk) begin
      bit was_idle;
      was_idle = (m_q.size() == 0);
      if (!reset) begin
         m_reset();
         m_hold = 2;
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (rst) begin
         m_reset();
      end else if (lfsr_load) begin
         if (seed == 64'h0) begin
            m_lfsr = DSEED;
            m_zf   = 1'b1;
         end else begin
            m_lfsr = seed;
         end
         m_q.delete();
      end else begin
         if (!was_idle && out_ready) void'(m_q.pop_front());
         if (was_idle && dump)
            for (int b = 0; b < int'(NB); b++)
               m_q.push_back(8'(m_lfsr >> (8 * (int'(NB) - 1 - b))));
         if (en) m_lfsr = lfsr_next(m_lfsr);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("lfsr_q", lfsr_q, m_lfsr);
         check("zero_fix", 64'(zero_fix), 64'(m_zf));
         check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
         check("busy", 64'(busy), 64'(m_q.size() != 0));
         check("out_last", 64'(out_last), 64'(m_q.size() == 1));
         if (m_q.size() != 0) check("out_data", 64'(out_data), 64'(m_q[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seed(input logic [63:0] v);
      lfsr_load = 1'b1;
      seed      = v;
      tick();
      lfsr_load = 1'b0;
   endtask

   logic [7:0] exp_b [8];
   bit         rdy   [11];
   logic [7:0] got[$];
   int         n45;

   initial begin
      exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      rdy   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      #3 reset = 1'b0;
      chk_on = 1'b1;
      #40 reset = 1'b1;
      repeat (4) tick();

      // Reset state
      check("rst_lfsr", lfsr_q, 64'h1);
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_data", 64'(out_data), 64'h0);
      check("rst_last", 64'(out_last), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_zf", 64'(zero_fix), 64'h0);

      // Single steps pinning the feedback taps
      en = 1'b1; tick(); en = 1'b0;
      check("step_from_1", lfsr_q, 64'h2);
      load_seed(64'h0800_0000_0000_0000);
      en = 1'b1; tick(); en = 1'b0;
      check("step_tap59", lfsr_q, 64'h1000_0000_0000_0001);
      load_seed(64'h8000_0000_0000_0000);
      en = 1'b1; tick(); en = 1'b0;
      check("step_wrap", lfsr_q, 64'h1);

      // Zero seed replacement, then sync clear with en ignored
      load_seed(64'h0);
      check("zero_seed_lfsr", lfsr_q, 64'h1);
      check("zero_seed_zf", 64'(zero_fix), 64'h1);
      rst = 1'b1; en = 1'b1; tick(); rst = 1'b0; en = 1'b0;
      check("clr_zf", 64'(zero_fix), 64'h0);
      check("clr_lfsr", lfsr_q, 64'h1);

      // Full-rate dump
      load_seed(SEQ);
      dump = 1'b1; out_ready = 1'b1; tick(); dump = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("dump_byte", 64'(out_data), 64'(exp_b[k]));
         check("dump_last", 64'(out_last), 64'(k == 7));
         check("dump_busy", 64'(busy), 64'h1);
         tick();
      end
      check("dump_done_busy", 64'(busy), 64'h0);
      check("dump_done_valid", 64'(out_valid), 64'h0);

      // Back-pressure on the third byte with stepping underneath
      load_seed(SEQ);
      en = 1'b1; dump = 1'b1; out_ready = 1'b1; tick(); dump = 1'b0;
      got.delete();
      n45 = 0;
      for (int i = 0; i < 11; i++) begin
         if (out_valid) begin
            if (out_data == 8'h45) n45++;
            if (rdy[i]) got.push_back(out_data);
         end
         out_ready = rdy[i];
         tick();
      end
      en = 1'b0;
      check("stall_count", 64'(got.size()), 64'd8);
      for (int k = 0; k < 8; k++)
         if (k < got.size()) check("stall_byte", 64'(got[k]), 64'(exp_b[k]));
      check("stall_hold45", 64'(n45), 64'd4);
      check("stall_busy_end", 64'(busy), 64'h0);

      // Load aborts a dump on the third byte
      load_seed(SEQ);
      dump = 1'b1; out_ready = 1'b1; tick(); dump = 1'b0;
      tick(); tick();
      check("abort_at_45", 64'(out_data), 64'h45);
      lfsr_load = 1'b1; seed = 64'hCAFE_F00D_1234_5678; tick(); lfsr_load = 1'b0;
      check("abort_valid", 64'(out_valid), 64'h0);
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_lfsr", lfsr_q, 64'hCAFE_F00D_1234_5678);

      // Asynchronous reset pulse mid-dump
      load_seed(64'h0);
      load_seed(SEQ);
      dump = 1'b1; tick(); dump = 1'b0;
      tick();
      #2 reset = 1'b0;
      #1;
      check("areset_valid", 64'(out_valid), 64'h0);
      check("areset_data", 64'(out_data), 64'h0);
      check("areset_last", 64'(out_last), 64'h0);
      check("areset_busy", 64'(busy), 64'h0);
      check("areset_lfsr", lfsr_q, 64'h1);
      check("areset_zf", 64'(zero_fix), 64'h0);
      #8 reset = 1'b1;
      repeat (4) tick();
      check("post_areset_lfsr", lfsr_q, 64'h1);
      check("post_areset_busy", 64'(busy), 64'h0);

      // Randomized traffic
      repeat (3000) begin
         rst       = ($urandom_range(0, 99) < 2);
         lfsr_load = ($urandom_range(0, 99) < 4);
         seed      = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
         dump      = ($urandom_range(0, 99) < 12);
         en        = ($urandom_range(0, 99) < 50);
         out_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      rst = 1'b0; lfsr_load = 1'b0; dump = 1'b0; en = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
